// File: rtl/sr_flip_flop.sv
// Bank of WIDTH independent clocked SR bits with complementary outputs and a
// registered per-bit flag marking the forbidden S=R=1 input.
module sr_flip_flop #(
  parameter int unsigned          WIDTH        = 1,
  parameter int unsigned          INVALID_MODE = 0,
  parameter logic [WIDTH-1:0]     RESET_VAL    = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] S,
  input  logic [WIDTH-1:0] R,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qn,
  output logic [WIDTH-1:0] invalid
);

  typedef enum logic [1:0] {
    RES_HOLD   = 2'd0,
    RES_SET    = 2'd1,
    RES_CLR    = 2'd2,
    RES_TOGGLE = 2'd3
  } resolve_e;

  // Out-of-range mode values fall back to hold.
  function automatic resolve_e decode_mode(input int unsigned mode);
    case (mode)
      1:       return RES_SET;
      2:       return RES_CLR;
      3:       return RES_TOGGLE;
      default: return RES_HOLD;
    endcase
  endfunction

  localparam resolve_e RESOLVE = decode_mode(INVALID_MODE);

  logic [WIDTH-1:0] set_only;
  logic [WIDTH-1:0] clr_only;
  logic [WIDTH-1:0] both;
  logic [WIDTH-1:0] resolved;
  logic [WIDTH-1:0] q_next;

  always_comb begin
    set_only = S & ~R;
    clr_only = ~S & R;
    both     = S & R;
    case (RESOLVE)
      RES_SET:    resolved = '1;
      RES_CLR:    resolved = '0;
      RES_TOGGLE: resolved = ~Q;
      default:    resolved = Q;
    endcase
    // Bits with neither input hold; set wins only alone; S=R=1 takes the resolved value.
    q_next = (Q & ~(set_only | clr_only | both)) | set_only | (both & resolved);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Q       <= RESET_VAL;
      invalid <= '0;
    end else begin
      Q       <= q_next;
      invalid <= both;
    end
  end

  assign Qn = ~Q;

endmodule

// File: tb/tb_sr_flip_flop.sv
// Directed bench: one DUT per resolution mode (plus an out-of-range mode) and a 4-bit bank.
module tb_sr_flip_flop;

  logic       clk = 1'b0;
  logic       rst;
  logic       s, r;
  logic [3:0] s4, r4;
  logic [4:0] q, qn, inv;
  logic [3:0] q4, qn4, inv4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(0)) u_m0 (
    .clk(clk), .rst(rst), .S(s), .R(r), .Q(q[0]), .Qn(qn[0]), .invalid(inv[0]));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(1)) u_m1 (
    .clk(clk), .rst(rst), .S(s), .R(r), .Q(q[1]), .Qn(qn[1]), .invalid(inv[1]));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(2)) u_m2 (
    .clk(clk), .rst(rst), .S(s), .R(r), .Q(q[2]), .Qn(qn[2]), .invalid(inv[2]));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(3)) u_m3 (
    .clk(clk), .rst(rst), .S(s), .R(r), .Q(q[3]), .Qn(qn[3]), .invalid(inv[3]));
  sr_flip_flop #(.WIDTH(1), .INVALID_MODE(5)) u_m5 (
    .clk(clk), .rst(rst), .S(s), .R(r), .Q(q[4]), .Qn(qn[4]), .invalid(inv[4]));
  sr_flip_flop #(.WIDTH(4), .INVALID_MODE(0), .RESET_VAL(4'b0000)) u_w4 (
    .clk(clk), .rst(rst), .S(s4), .R(r4), .Q(q4), .Qn(qn4), .invalid(inv4));

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Vectors are ordered {mode5, mode3, mode2, mode1, mode0}.
  task automatic chk_modes(input string tag, input logic [4:0] eq, input logic [4:0] einv);
    chk({tag, ".Q"}, q, eq);
    chk({tag, ".Qn"}, qn, ~eq);
    chk({tag, ".inv"}, inv, einv);
  endtask

  task automatic chk_wide(input string tag, input logic [3:0] eq, input logic [3:0] einv);
    chk({tag, ".Q4"}, {1'b0, q4}, {1'b0, eq});
    chk({tag, ".Qn4"}, {1'b0, qn4}, {1'b0, ~eq});
    chk({tag, ".inv4"}, {1'b0, inv4}, {1'b0, einv});
  endtask

  task automatic step(input logic rst_v, input logic s_v, input logic r_v);
    @(negedge clk);
    rst = rst_v;
    s   = s_v;
    r   = r_v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; s = 1'b0; r = 1'b0; s4 = '0; r4 = '0;

    step(1'b1, 1'b0, 1'b0);
    chk_modes("reset", 5'b00000, 5'b00000);
    chk_wide("reset", 4'b0000, 4'b0000);

    step(1'b0, 1'b1, 1'b0);
    chk_modes("set", 5'b11111, 5'b00000);
    step(1'b0, 1'b0, 1'b1);
    chk_modes("clear", 5'b00000, 5'b00000);

    step(1'b0, 1'b1, 1'b0);
    chk_modes("set2", 5'b11111, 5'b00000);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_modes("hold", 5'b11111, 5'b00000);
    end

    step(1'b0, 1'b0, 1'b1);
    chk_modes("clear2", 5'b00000, 5'b00000);
    step(1'b0, 1'b1, 1'b1);
    chk_modes("sr11_from0", 5'b01010, 5'b11111);
    step(1'b0, 1'b1, 1'b1);
    chk_modes("sr11_again", 5'b00010, 5'b11111);
    step(1'b0, 1'b0, 1'b0);
    chk_modes("after_sr11", 5'b00010, 5'b00000);

    step(1'b0, 1'b1, 1'b0);
    chk_modes("set3", 5'b11111, 5'b00000);
    step(1'b0, 1'b1, 1'b1);
    chk_modes("sr11_from1", 5'b10011, 5'b11111);

    step(1'b0, 1'b1, 1'b0);
    chk_modes("set4", 5'b11111, 5'b00000);
    step(1'b1, 1'b1, 1'b0);
    chk_modes("rst_over_set", 5'b00000, 5'b00000);
    step(1'b0, 1'b1, 1'b0);
    chk_modes("set_after_rst", 5'b11111, 5'b00000);

    step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    chk_modes("rst_over_sr11", 5'b00000, 5'b00000);

    step(1'b1, 1'b0, 1'b0);
    chk_wide("wide_reset", 4'b0000, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    s4  = 4'b1010;
    r4  = 4'b0110;
    @(posedge clk);
    #1;
    chk_wide("wide_mix", 4'b1000, 4'b0010);
    @(negedge clk);
    s4 = '0;
    r4 = '0;
    @(posedge clk);
    #1;
    chk_wide("wide_hold", 4'b1000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
